// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer.
// Contents:
//   DEF_WIDTH / DEF_OPW - default operand and op-code widths
//   state_t             - operating-state encoding (visible on the debug port)
//   KEY_*               - decoded key-class codes
//   nsr_cmd_t           - command set of the nibble shift register
package calc_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_OPW   = 2;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_OP   = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_RES  = 3'd4
    } state_t;

    localparam logic [1:0] KEY_DIGIT = 2'b00;
    localparam logic [1:0] KEY_OP    = 2'b01;
    localparam logic [1:0] KEY_EQ    = 2'b10;
    localparam logic [1:0] KEY_CLR   = 2'b11;

    typedef enum logic [2:0] {
        NSR_HOLD      = 3'd0,
        NSR_CLR       = 3'd1,
        NSR_LOAD_NIB  = 3'd2,
        NSR_SHIFT     = 3'd3,
        NSR_LOAD_WORD = 3'd4
    } nsr_cmd_t;

endpackage

// File: rtl/calc_sequencer_if.sv
// Key-decoder and ULA signal bundle of the calculator sequencer.
// Modports:
//   slave  - the sequencer: takes key events and ULA done/result, drives launch,
//            operands, operator, display, busy and debug state
//   master - the environment (key decoder + ULA side), the mirror image
interface calc_sequencer_if #(
    parameter int unsigned WIDTH = calc_pkg::DEF_WIDTH,
    parameter int unsigned OPW   = calc_pkg::DEF_OPW
);
    logic             key_valid;
    logic [1:0]       key_cls;
    logic [3:0]       key_data;
    logic             alu_done;
    logic [WIDTH-1:0] alu_result;
    logic             alu_start;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] display;
    logic             busy;
    logic [2:0]       state;

    modport slave (
        input  key_valid, key_cls, key_data, alu_done, alu_result,
        output alu_start, alu_a, alu_b, alu_op, display, busy, state
    );

    modport master (
        output key_valid, key_cls, key_data, alu_done, alu_result,
        input  alu_start, alu_a, alu_b, alu_op, display, busy, state
    );
endinterface

// File: rtl/nibble_shift_reg.sv
// WIDTH-bit operand register fed one hex digit at a time.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (clears q)
//   cmd        - HOLD / CLR / LOAD_NIB (zero-extended) / SHIFT (nibble in at LSB,
//                oldest nibble dropped) / LOAD_WORD (full-width load from word)
//   nib        - digit nibble
//   word       - full-width load value
//   q          - register contents
module nibble_shift_reg
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  nsr_cmd_t         cmd,
    input  logic [3:0]       nib,
    input  logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] shifted;

    // A single-nibble register has nothing to keep when shifting.
    if (WIDTH == 4) begin : g_one_nib
        assign shifted = nib;
    end else begin : g_multi_nib
        assign shifted = {q[WIDTH-5:0], nib};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            case (cmd)
                NSR_CLR:       q <= '0;
                NSR_LOAD_NIB:  q <= WIDTH'(nib);
                NSR_SHIFT:     q <= shifted;
                NSR_LOAD_WORD: q <= word;
                default:       q <= q;
            endcase
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator operating-state machine: collects operand A, operator and operand B
// from key events, launches the ULA with a one-cycle start pulse, waits for done
// (unbounded latency) and holds the result for display.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - calc_sequencer_if.slave: key events in, ULA handshake, operands,
//                operator, display, busy and debug state out
// Build option:
//   CALC_CHAIN_EN - when defined, an operator key in S_RES moves the result into
//                   A and starts a new operation; otherwise it is ignored.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned OPW   = DEF_OPW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    calc_sequencer_if.slave         bus
);

    state_t           state_q;
    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] result_q;
    logic             start_q;
    logic             busy_q;
    logic             pend_clr_q;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    nsr_cmd_t         a_cmd;
    nsr_cmd_t         b_cmd;

    logic key_dig, key_op, key_eq, key_clr;
    logic abort;

    assign key_dig = bus.key_valid && (bus.key_cls == KEY_DIGIT);
    assign key_op  = bus.key_valid && (bus.key_cls == KEY_OP);
    assign key_eq  = bus.key_valid && (bus.key_cls == KEY_EQ);
    assign key_clr = bus.key_valid && (bus.key_cls == KEY_CLR);

    // Completion of an operation that was cancelled earlier or is being cancelled now.
    assign abort = bus.alu_done && (pend_clr_q || key_clr);

    nibble_shift_reg #(.WIDTH(WIDTH)) u_reg_a (
        .clk  (clk),
        .rst_n(rst_n),
        .cmd  (a_cmd),
        .nib  (bus.key_data),
        .word (result_q),
        .q    (a_q)
    );

    nibble_shift_reg #(.WIDTH(WIDTH)) u_reg_b (
        .clk  (clk),
        .rst_n(rst_n),
        .cmd  (b_cmd),
        .nib  (bus.key_data),
        .word ('0),
        .q    (b_q)
    );

    // Operand register commands.
    always_comb begin
        a_cmd = NSR_HOLD;
        b_cmd = NSR_HOLD;
        if (key_clr && (state_q != S_EXEC)) begin
            a_cmd = NSR_CLR;
            b_cmd = NSR_CLR;
        end else begin
            case (state_q)
                S_A:    if (key_dig) a_cmd = NSR_SHIFT;
                S_OP:   if (key_dig) b_cmd = NSR_LOAD_NIB;
                S_B:    if (key_dig) b_cmd = NSR_SHIFT;
                S_EXEC: begin
                    if (abort) begin
                        a_cmd = NSR_CLR;
                        b_cmd = NSR_CLR;
                    end
                end
                S_RES: begin
                    if (key_dig) begin
                        a_cmd = NSR_LOAD_NIB;
                        b_cmd = NSR_CLR;
                    end
`ifdef CALC_CHAIN_EN
                    else if (key_op) begin
                        a_cmd = NSR_LOAD_WORD;
                        b_cmd = NSR_CLR;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_A;
            op_q       <= '0;
            result_q   <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            pend_clr_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (key_clr && (state_q != S_EXEC)) begin
                op_q       <= '0;
                result_q   <= '0;
                pend_clr_q <= 1'b0;
                state_q    <= S_A;
            end else begin
                case (state_q)
                    S_A: begin
                        if (key_op) begin
                            op_q    <= bus.key_data[OPW-1:0];
                            state_q <= S_OP;
                        end
                    end
                    S_OP: begin
                        if (key_dig) begin
                            state_q <= S_B;
                        end else if (key_op) begin
                            op_q <= bus.key_data[OPW-1:0];
                        end
                    end
                    S_B: begin
                        if (key_eq) begin
                            start_q <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        if (bus.alu_done) begin
                            busy_q <= 1'b0;
                            if (abort) begin
                                op_q       <= '0;
                                result_q   <= '0;
                                pend_clr_q <= 1'b0;
                                state_q    <= S_A;
                            end else begin
                                result_q <= bus.alu_result;
                                state_q  <= S_RES;
                            end
                        end else if (key_clr) begin
                            pend_clr_q <= 1'b1;
                        end
                    end
                    S_RES: begin
                        if (key_dig) begin
                            state_q <= S_A;
                        end
`ifdef CALC_CHAIN_EN
                        else if (key_op) begin
                            op_q    <= bus.key_data[OPW-1:0];
                            state_q <= S_OP;
                        end
`endif
                    end
                    default: state_q <= S_A;
                endcase
            end
        end
    end

    always_comb begin
        bus.display = a_q;
        case (state_q)
            S_A, S_OP:   bus.display = a_q;
            S_B, S_EXEC: bus.display = b_q;
            S_RES:       bus.display = result_q;
            default:     bus.display = a_q;
        endcase
    end

    assign bus.alu_start = start_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_op    = op_q;
    assign bus.busy      = busy_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: expected ULA launches are queued when
// equals is pressed and compared when alu_start appears; state/display checks
// are made directly against constants.
module tb_calc_sequencer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned OPW   = 2;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [OPW-1:0]   op;
    } launch_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    bit   seen_res;
    launch_t sb[$];

    calc_sequencer_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

    calc_sequencer #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; each task returns on the falling edge
    // after the rising edge that consumed the input.
    task automatic press_key(input logic [1:0] cls, input logic [3:0] data);
        bus.key_valid = 1'b1;
        bus.key_cls   = cls;
        bus.key_data  = data;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic pulse_done(input logic [WIDTH-1:0] res);
        bus.alu_done   = 1'b1;
        bus.alu_result = res;
        @(negedge clk);
        bus.alu_done = 1'b0;
    endtask

    task automatic push_launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [OPW-1:0] op);
        launch_t l;
        l.a  = a;
        l.b  = b;
        l.op = op;
        sb.push_back(l);
    endtask

    // Launch scoreboard and S_RES tracker.
    always @(negedge clk) begin
        if (bus.state == 3'd4) seen_res = 1'b1;
        if (rst_n && bus.alu_start) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_start", 32'd1, 32'd0);
            end else begin
                launch_t l;
                l = sb.pop_front();
                check_eq("launch_a", 32'(bus.alu_a), 32'(l.a));
                check_eq("launch_b", 32'(bus.alu_b), 32'(l.b));
                check_eq("launch_op", 32'(bus.alu_op), 32'(l.op));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        seen_res = 1'b0;
        rst_n = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_cls = 2'b00;
        bus.key_data = 4'h0;
        bus.alu_done = 1'b0;
        bus.alu_result = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_eq("rst_state", 32'(bus.state), 32'd0);
        check_eq("rst_display", 32'(bus.display), 32'h00);
        check_eq("rst_start", 32'(bus.alu_start), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);

        // 0x3A op1 0x05 =
        press_key(2'b00, 4'h3);
        press_key(2'b00, 4'hA);
        press_key(2'b01, 4'h1);
        press_key(2'b00, 4'h0);
        press_key(2'b00, 4'h5);
        check_eq("b_display", 32'(bus.display), 32'h05);
        push_launch(8'h3A, 8'h05, 2'd1);
        press_key(2'b10, 4'h0);
        check_eq("exec_state", 32'(bus.state), 32'd3);
        check_eq("exec_busy", 32'(bus.busy), 32'd1);
        check_eq("exec_start", 32'(bus.alu_start), 32'd1);
        @(negedge clk);
        check_eq("start_one_cycle", 32'(bus.alu_start), 32'd0);
        press_key(2'b10, 4'h0);
        check_eq("no_retrigger", 32'(bus.alu_start), 32'd0);
        @(negedge clk);
        pulse_done(8'h3F);
        check_eq("res_state", 32'(bus.state), 32'd4);
        check_eq("res_display", 32'(bus.display), 32'h3F);
        check_eq("res_busy", 32'(bus.busy), 32'd0);

        // Operator key in S_RES
        press_key(2'b01, 4'h2);
`ifdef CALC_CHAIN_EN
        check_eq("chain_state", 32'(bus.state), 32'd1);
        check_eq("chain_a", 32'(bus.alu_a), 32'h3F);
        check_eq("chain_op", 32'(bus.alu_op), 32'd2);
        press_key(2'b00, 4'h1);
        push_launch(8'h3F, 8'h01, 2'd2);
        press_key(2'b10, 4'h0);
        @(negedge clk);
        pulse_done(8'h40);
        check_eq("chain_res", 32'(bus.display), 32'h40);
`else
        check_eq("nochain_state", 32'(bus.state), 32'd4);
        check_eq("nochain_display", 32'(bus.display), 32'h3F);
        press_key(2'b00, 4'h1);
        check_eq("res_digit_state", 32'(bus.state), 32'd0);
        check_eq("res_digit_a", 32'(bus.alu_a), 32'h01);
        check_eq("res_digit_b", 32'(bus.alu_b), 32'h00);
`endif
        press_key(2'b11, 4'h0);
        check_eq("clr_state", 32'(bus.state), 32'd0);
        check_eq("clr_a", 32'(bus.alu_a), 32'h00);
        check_eq("clr_op", 32'(bus.alu_op), 32'd0);

        // Wrap, ignored keys
        press_key(2'b00, 4'h1);
        press_key(2'b00, 4'h2);
        press_key(2'b00, 4'h3);
        check_eq("wrap_a", 32'(bus.alu_a), 32'h23);
        press_key(2'b10, 4'h0);
        check_eq("eq_in_a", 32'(bus.state), 32'd0);
        press_key(2'b01, 4'h1);
        press_key(2'b01, 4'h3);
        check_eq("op_replace", 32'(bus.alu_op), 32'd3);
        press_key(2'b01, 4'h1);
        press_key(2'b00, 4'h4);
        check_eq("op_display_b", 32'(bus.display), 32'h04);
        press_key(2'b01, 4'h2);
        check_eq("op_in_b_state", 32'(bus.state), 32'd2);
        check_eq("op_in_b_op", 32'(bus.alu_op), 32'd1);

        // Clear during S_EXEC, done 3 cycles later
        push_launch(8'h23, 8'h04, 2'd1);
        press_key(2'b10, 4'h0);
        seen_res = 1'b0;
        press_key(2'b11, 4'h0);
        check_eq("pend_state", 32'(bus.state), 32'd3);
        check_eq("pend_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        pulse_done(8'h77);
        check_eq("pend_done_state", 32'(bus.state), 32'd0);
        check_eq("pend_done_display", 32'(bus.display), 32'h00);
        check_eq("pend_done_b", 32'(bus.alu_b), 32'h00);
        check_eq("pend_no_res", 32'(seen_res), 32'd0);

        // Clear and done in the same cycle
        press_key(2'b00, 4'h5);
        press_key(2'b01, 4'h3);
        press_key(2'b00, 4'h6);
        push_launch(8'h05, 8'h06, 2'd3);
        press_key(2'b10, 4'h0);
        seen_res = 1'b0;
        @(negedge clk);
        bus.key_valid  = 1'b1;
        bus.key_cls    = 2'b11;
        bus.alu_done   = 1'b1;
        bus.alu_result = 8'h77;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.alu_done  = 1'b0;
        check_eq("same_cyc_state", 32'(bus.state), 32'd0);
        check_eq("same_cyc_display", 32'(bus.display), 32'h00);
        @(negedge clk);
        check_eq("same_cyc_no_res", 32'(seen_res), 32'd0);

        // Asynchronous reset mid-S_EXEC
        press_key(2'b00, 4'h7);
        press_key(2'b01, 4'h1);
        press_key(2'b00, 4'h8);
        push_launch(8'h07, 8'h08, 2'd1);
        press_key(2'b10, 4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_start", 32'(bus.alu_start), 32'd0);
        check_eq("arst_state", 32'(bus.state), 32'd0);
        check_eq("arst_display", 32'(bus.display), 32'h00);
        check_eq("arst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_done(8'h99);
        check_eq("late_done_state", 32'(bus.state), 32'd0);
        check_eq("late_done_display", 32'(bus.display), 32'h00);

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
